// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART program loader.
// Optional echo path is enabled by defining UART_LOADER_ECHO_EN.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    GET_SUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // One bit time at 9600 baud from a 50 MHz clock.
  localparam int CLKS_PER_BIT = 5208;

  // Two 10-bit byte frames of silence before a load is abandoned.
  localparam int TIMEOUT_CLKS_DEF = 20 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_loader_timeout.sv
// Reloadable inter-byte down-counter; expire is high while enabled and the count is exhausted.
module uart_loader_timeout #(
  parameter int TIMEOUT_CLKS = uart_loader_pkg::TIMEOUT_CLKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  // Loading TIMEOUT_CLKS-1 makes expire assert TIMEOUT_CLKS cycles after the reloading byte.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (reload) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/uart_loader_ctrl.sv
// Framed UART program loader: sync, length, data bytes, checksum -> RAM writes.
// Define UART_LOADER_ECHO_EN to echo every byte accepted inside a frame.
module uart_loader_ctrl
  import uart_loader_pkg::*;
#(
  parameter int                ADDR_W       = 4,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int                TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [DATA_W-1:0] rx_byte,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_halt,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_busy
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [DATA_W-1:0] MAX_LEN_B = DATA_W'(2 ** ADDR_W);

  state_t            state;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] checksum;
  logic              in_frame;
  logic              len_ok;
  logic              expire;

  assign in_frame = (state == GET_LEN) || (state == GET_DATA) || (state == GET_SUM);
  assign len_ok   = (rx_byte != '0) && (rx_byte <= MAX_LEN_B);

  uart_loader_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .reload(rx_dv),
    .enable(in_frame),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_we    <= 1'b0;
      cpu_halt  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len       <= '0;
      count     <= '0;
      checksum  <= '0;
    end else begin
      ram_we    <= 1'b0;
      load_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_dv && (rx_byte == SYNC_BYTE)) begin
            state    <= GET_LEN;
            busy     <= 1'b1;
            cpu_halt <= 1'b1;
            load_err <= 1'b0;
            checksum <= '0;
          end
        end
        GET_LEN: begin
          // A byte on the expiry cycle still counts, so rx_dv is tested first.
          if (rx_dv) begin
            if (len_ok) begin
              len   <= rx_byte[CNT_W-1:0];
              count <= '0;
              state <= GET_DATA;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end else if (expire) begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_dv) begin
            ram_we   <= 1'b1;
            ram_addr <= count[ADDR_W-1:0];
            ram_data <= rx_byte;
            checksum <= checksum + rx_byte;
            count    <= count + 1'b1;
            if (count == len - 1'b1) begin
              state <= GET_SUM;
            end
          end else if (expire) begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
        GET_SUM: begin
          if (rx_dv) begin
            if (rx_byte == checksum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_halt  <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end else if (expire) begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_LOADER_ECHO_EN
  // Echo is best-effort: a byte arriving while the transmitter is busy is not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_dv   <= 1'b0;
      tx_byte <= '0;
    end else begin
      tx_dv <= 1'b0;
      if (rx_dv && in_frame && !tx_busy) begin
        tx_dv   <= 1'b1;
        tx_byte <= rx_byte;
      end
    end
  end
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_dv          = 1'b0;
  assign tx_byte        = '0;
`endif

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Scoreboard bench for uart_loader_ctrl: frame-level model pushes expected events, a monitor pops them.
module tb_uart_loader_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_halt;
  logic       busy;
  logic       load_done;
  logic       load_err;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_busy;

  uart_loader_ctrl #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .cpu_halt (cpu_halt),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t wr_q[$];
  ev_t done_q[$];
  ev_t err_q[$];
  ev_t echo_q[$];

  int   n_vec = 0;
  int   n_err = 0;
  bit   exp_err = 1'b0;
  bit   exp_halt = 1'b0;
  logic [7:0] fdata [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (ram_we) begin
        if (wr_q.size() == 0) unexpected("write");
        else begin
          e = wr_q.pop_front();
          $display("write  cyc=%0d addr=%0h data=%02h", cyc, ram_addr, ram_data);
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("write_addr", 32'(ram_addr), 32'(e.a));
          chk("write_data", 32'(ram_data), 32'(e.d));
        end
      end
      if (load_done) begin
        if (done_q.size() == 0) unexpected("load_done");
        else begin
          e = done_q.pop_front();
          $display("done   cyc=%0d", cyc);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_halt", 32'(cpu_halt), 32'(0));
          chk("done_busy", 32'(busy), 32'(1));
        end
      end
      if (load_err && !prev_err) begin
        if (err_q.size() == 0) unexpected("load_err");
        else begin
          e = err_q.pop_front();
          $display("error  cyc=%0d", cyc);
          chk("err_cycle", 32'(cyc), 32'(e.cyc));
          chk("err_halt", 32'(cpu_halt), 32'(1));
          chk("err_busy", 32'(busy), 32'(1));
        end
      end
      if (tx_dv) begin
        if (echo_q.size() == 0) unexpected("echo");
        else begin
          e = echo_q.pop_front();
          $display("echo   cyc=%0d byte=%02h", cyc, tx_byte);
          chk("echo_cycle", 32'(cyc), 32'(e.cyc));
          chk("echo_byte", 32'(tx_byte), 32'(e.d));
        end
      end
    end
    prev_err = load_err;
  end

  function automatic ev_t mk(input int c, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = c;
    e.a   = a;
    e.d   = d;
    return e;
  endfunction

  // Drives one byte 'gap' cycles after the previous one; t is the cycle rx_dv is high.
  task automatic send_raw(input logic [7:0] b, input int gap, output int t);
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
    rx_dv   = 1'b1;
    rx_byte = b;
    t       = cyc;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  // A byte taken inside a frame: echoed one cycle later when the transmitter is idle.
  task automatic send_acc(input logic [7:0] b, input int gap, output int t);
    send_raw(b, gap, t);
`ifdef UART_LOADER_ECHO_EN
    if (!tx_busy) echo_q.push_back(mk(t + 1, 8'h00, b));
`endif
  endtask

  // Sends a whole frame from fdata; sum_delta != 0 corrupts the checksum.
  task automatic run_frame(input int len, input logic [7:0] sum_delta, input int gmax);
    int         t;
    logic [7:0] sum;
    send_raw(8'hA5, 3 + $urandom_range(0, 2), t);
    send_acc(8'(len), $urandom_range(1, gmax), t);
    if (len < 1 || len > 16) begin
      err_q.push_back(mk(t + 1, 8'h00, 8'h00));
      exp_err  = 1'b1;
      exp_halt = 1'b1;
      return;
    end
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      send_acc(fdata[i], $urandom_range(1, gmax), t);
      wr_q.push_back(mk(t + 1, 8'(i), fdata[i]));
      sum = sum + fdata[i];
    end
    send_acc(sum + sum_delta, $urandom_range(1, gmax), t);
    if (sum_delta == 8'h00) begin
      done_q.push_back(mk(t + 1, 8'h00, 8'h00));
      exp_err  = 1'b0;
      exp_halt = 1'b0;
    end else begin
      err_q.push_back(mk(t + 1, 8'h00, 8'h00));
      exp_err  = 1'b1;
      exp_halt = 1'b1;
    end
  endtask

  task automatic settle_and_check(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_load_err"}, 32'(load_err), 32'(exp_err));
    chk({name, "_cpu_halt"}, 32'(cpu_halt), 32'(exp_halt));
    chk({name, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ram"}, {19'b0, ram_addr, ram_data, ram_we}, 32'(0));
    chk({name, "_ctl"}, {28'b0, cpu_halt, busy, load_done, load_err}, 32'(0));
    chk({name, "_tx"}, {23'b0, tx_dv, tx_byte}, 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    tx_busy = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Good three-byte frame.
    fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33;
    run_frame(3, 8'h00, 1);
    settle_and_check("good3");

    // Bad checksum (31 instead of 30), then a good frame clears the error.
    fdata[0] = 8'h10; fdata[1] = 8'h20;
    run_frame(2, 8'h01, 1);
    settle_and_check("badsum");
    fdata[0] = 8'hA5;
    run_frame(1, 8'h00, 2);
    settle_and_check("recover");

    // Out-of-range lengths.
    run_frame(0, 8'h00, 1);
    settle_and_check("len00");
    run_frame(17, 8'h00, 1);
    settle_and_check("len11");

    // Silence after one data byte: error exactly TO cycles after it.
    send_raw(8'hA5, 3, t);
    send_acc(8'h04, 1, t);
    send_acc(8'h01, 1, t);
    wr_q.push_back(mk(t + 1, 8'h00, 8'h01));
    err_q.push_back(mk(t + TO + 1, 8'h00, 8'h00));
    exp_err = 1'b1; exp_halt = 1'b1;
    repeat (TO + 4) @(posedge clk);
    #1;
    settle_and_check("timeout");

    // Bytes arriving on the exact expiry cycle are still accepted.
    send_raw(8'hA5, 3, t);
    send_acc(8'h01, TO, t);
    send_acc(8'h5C, TO, t);
    wr_q.push_back(mk(t + 1, 8'h00, 8'h5C));
    send_acc(8'h5C, TO, t);
    done_q.push_back(mk(t + 1, 8'h00, 8'h00));
    exp_err = 1'b0; exp_halt = 1'b0;
    settle_and_check("expiry_edge");

    // Reset in the middle of the data phase.
    send_raw(8'hA5, 3, t);
    send_acc(8'h05, 1, t);
    send_acc(8'hC1, 1, t);
    wr_q.push_back(mk(t + 1, 8'h00, 8'hC1));
    send_acc(8'hC2, 1, t);
    wr_q.push_back(mk(t + 1, 8'h01, 8'hC2));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midload_rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    exp_err = 1'b0; exp_halt = 1'b0;
    send_raw(8'h5A, 1, t);
    settle_and_check("idle_5a");

    // Echo frame with transmitter idle, then with it busy.
    fdata[0] = 8'h7E;
    tx_busy = 1'b0;
    run_frame(1, 8'h00, 1);
    settle_and_check("echo_idle");
    tx_busy = 1'b1;
    run_frame(1, 8'h00, 1);
    settle_and_check("echo_busy");

    // Randomized frames, including garbage in idle, bad lengths and bad checksums.
    for (int f = 0; f < 40; f++) begin
      int len;
      logic [7:0] delta;
      tx_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_raw(g, 3, t);
      end
      len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255))
                                        : $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom_range(0, 255));
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(len, delta, 4);
      settle_and_check("random");
    end

    repeat (5) @(posedge clk);
    #1;
    chk("writes_left", 32'(wr_q.size()), 32'(0));
    chk("dones_left", 32'(done_q.size()), 32'(0));
    chk("errors_left", 32'(err_q.size()), 32'(0));
    chk("echoes_left", 32'(echo_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_loader_ctrl.md
Name: uart_loader_ctrl

Overview:
- Sequences UART program loading into the 16-byte RAM of the 8-bit computer. Sits between the UART receiver's byte-valid/byte outputs and the RAM write port.
- Parses a framed packet: sync, length, data bytes, checksum.
- Issues one RAM write per data byte and holds the CPU halted while a load is in progress.
- Reports success or failure on status outputs.

Parameters:
- ADDR_W, 4, RAM address width; max payload is 2**ADDR_W bytes.
- DATA_W, 8, byte width; fixed at 8 for the protocol.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 104160, inter-byte timeout in clk cycles (about 2 byte-times at 9600 baud with a 50 MHz clock).

Ports:
- clk  in  1  system clock (50 MHz domain, same as the UART receiver)
- rst  in  1  asynchronous, active-high reset
- rx_dv  in  1  one-cycle pulse: rx_byte valid
- rx_byte  in  8  received byte
- ram_addr  out  ADDR_W  RAM write address
- ram_data  out  8  RAM write data
- ram_we  out  1  one-cycle RAM write strobe
- cpu_halt  out  1  high while a load is in progress or after a failed load
- busy  out  1  high in any state other than IDLE
- load_done  out  1  one-cycle pulse on a good frame
- load_err  out  1  sticky error flag
- tx_dv  out  1  echo byte valid (feature only; otherwise 0)
- tx_byte  out  8  echo byte (feature only; otherwise 0)
- tx_busy  in  1  UART transmitter is active

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = IDLE.
  - All outputs = 0.
  - Byte counter, checksum and timeout counter = 0.
- Reset mid-load aborts the load immediately. RAM contents already written are not restored.
- FSM states: IDLE, GET_LEN, GET_DATA, GET_SUM, DONE, ERR.
- IDLE:
  - rx_dv with rx_byte == SYNC_BYTE -> GET_LEN.
  - Next cycle: cpu_halt = 1, load_err cleared, checksum = 0.
  - Any other byte is ignored.
- GET_LEN:
  - The length byte N must be in 1..2**ADDR_W; otherwise -> ERR.
  - A valid N is latched; addr counter = 0 -> GET_DATA.
- GET_DATA, on each rx_dv:
  - Next cycle: ram_we = 1 for one cycle, ram_addr = counter, ram_data = rx_byte.
  - checksum += rx_byte (mod 256).
  - counter increments. After the Nth byte -> GET_SUM.
- GET_SUM:
  - Received byte == checksum -> DONE; otherwise -> ERR.
- DONE:
  - One cycle: load_done pulses, cpu_halt = 0 -> IDLE.
- ERR:
  - One cycle: load_err = 1 (sticky), cpu_halt stays 1 -> IDLE.
  - Only the next valid sync byte or rst clears load_err.
- Timeout:
  - In GET_LEN, GET_DATA and GET_SUM, a counter reloads on every rx_dv.
  - Reaching TIMEOUT_CLKS -> ERR.
  - If rx_dv and expiry occur in the same cycle, rx_dv wins.
- Latency: rx_dv to ram_we is exactly 1 cycle.
- ram_addr and ram_data hold their last values when ram_we = 0.
- Address never wraps: the length check guarantees counter < 2**ADDR_W.
- rx_dv arriving in DONE or ERR is dropped.
- A sync byte value inside data, length or checksum fields is treated as data, not as a restart.

Optional Feature:
- Macro: UART_LOADER_ECHO_EN.
- Defined:
  - Every byte accepted outside IDLE is echoed.
  - tx_byte = rx_byte and tx_dv pulses 1 cycle after rx_dv, if tx_busy = 0.
  - If tx_busy = 1, the echo for that byte is dropped (no queue).
- Undefined: tx_dv and tx_byte are tied to 0 and tx_busy is unused.

Decomposition:
- Shared package uart_loader_pkg:
  - state enum typedef.
  - SYNC_BYTE default.
  - Default TIMEOUT_CLKS.
  - CLKS_PER_BIT constant (5208).
- One natural sub-module, uart_loader_timeout: a reloadable down-counter with reload/enable inputs and an expire output.

Test Plan:
- Send A5, 03, 11, 22, 33, 66 -> ram_we three times, at addr 0/1/2 with data 11/22/33, one cycle after each rx_dv. Then load_done pulses once, cpu_halt falls, load_err = 0.
- Send A5, 02, 10, 20, 31 -> two writes occur, then load_err = 1, cpu_halt stays 1, no load_done. A following good frame clears load_err.
- Length bytes 00 and 11 -> ERR immediately after the length byte, no ram_we.
- Send A5, 04, 01, then silence -> after TIMEOUT_CLKS, load_err = 1.
- Separately, a byte arriving on the exact expiry cycle is accepted as data.
- Assert rst during GET_DATA after 2 bytes -> all outputs 0 immediately. A subsequent 5A byte in IDLE is ignored (busy = 0).
- With UART_LOADER_ECHO_EN defined, run the frame A5, 01, 7E, 7E -> tx_dv pulses for 01, 7E, 7E while tx_busy = 0. Holding tx_busy = 1 suppresses the echoes.
